// File: rtl/div_sched_pkg.sv
// Shared definitions for the divide scheduler: state encodings, iteration count and widths.
package div_sched_pkg;
    localparam int DataW   = 32;
    localparam int ResultW = 2 * DataW;
    localparam int DivIter = 32;
    localparam int CntW    = $clog2(DivIter);

    typedef enum logic [1:0] {
        DivIdle = 2'd0,
        DivBusy = 2'd1,
        DivDone = 2'd2
    } div_state_e;

    // Magnitude of an operand; only negative values in signed mode are negated.
    function automatic logic [DataW-1:0] mag32(input logic [DataW-1:0] v, input logic sgn);
        if (sgn && v[DataW-1]) begin
            mag32 = {DataW{1'b0}} - v;
        end else begin
            mag32 = v;
        end
    endfunction
endpackage

// File: rtl/div_sched_core.sv
// Radix-2 restoring divide datapath on unsigned magnitudes; one quotient bit per step.
module div_core
    import div_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [DataW-1:0] i_a_mag,
    input  logic [DataW-1:0] i_b_mag,
    output logic [DataW-1:0] o_quo_nxt,
    output logic [DataW-1:0] o_rem_nxt
);
    logic [DataW-1:0] r_quo;
    logic [DataW-1:0] r_rem;
    logic [DataW-1:0] r_b;
    logic [DataW:0]   w_shift;
    logic [DataW:0]   w_diff;

    // Trial subtraction: the dividend shifts out of r_quo while quotient bits shift in.
    always_comb begin
        w_shift = {r_rem, r_quo[DataW-1]};
        w_diff  = w_shift - {1'b0, r_b};
        if (!w_diff[DataW]) begin
            o_rem_nxt = w_diff[DataW-1:0];
            o_quo_nxt = {r_quo[DataW-2:0], 1'b1};
        end else begin
            o_rem_nxt = w_shift[DataW-1:0];
            o_quo_nxt = {r_quo[DataW-2:0], 1'b0};
        end
    end

    // Operand load on accept, then one iteration per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo <= {DataW{1'b0}};
            r_rem <= {DataW{1'b0}};
            r_b   <= {DataW{1'b0}};
        end else if (i_load) begin
            r_quo <= i_a_mag;
            r_rem <= {DataW{1'b0}};
            r_b   <= i_b_mag;
        end else if (i_step) begin
            r_quo <= o_quo_nxt;
            r_rem <= o_rem_nxt;
        end else begin
            r_quo <= r_quo;
            r_rem <= r_rem;
            r_b   <= r_b;
        end
    end
endmodule

// File: rtl/div_sched.sv
// Divide scheduler shared by two EX pipes: arbitration, FSM, sign fix-up and stalls.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and |a|<|b| in one cycle.
module div_sched
    import div_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic               req1_valid,
    input  logic               req0_signed,
    input  logic               req1_signed,
    input  logic [DataW-1:0]   req0_a,
    input  logic [DataW-1:0]   req0_b,
    input  logic [DataW-1:0]   req1_a,
    input  logic [DataW-1:0]   req1_b,
    input  logic               annul_i,
    output logic [ResultW-1:0] result_o,
    output logic               result_valid_o,
    output logic               result_id_o,
    output logic               stall0_o,
    output logic               stall1_o,
    output logic               busy_o
);
    localparam logic [CntW-1:0] LastCnt = CntW'(DivIter - 1);

    div_state_e         r_state;
    logic [CntW-1:0]    r_cnt;
    logic [DataW-1:0]   r_a;
    logic               r_b_zero;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [ResultW-1:0] r_result;
    logic               r_valid;
    logic               r_id;

    logic               w_accept;
    logic               w_sel1;
    logic               w_sgn;
    logic [DataW-1:0]   w_a;
    logic [DataW-1:0]   w_b;
    logic [DataW-1:0]   w_a_mag;
    logic [DataW-1:0]   w_b_mag;
    logic [DataW-1:0]   w_quo_nxt;
    logic [DataW-1:0]   w_rem_nxt;
    logic [ResultW-1:0] w_final;
`ifdef DIV_EARLY_OUT_EN
    logic               w_early;
    logic [ResultW-1:0] w_early_res;
`endif

    // Older pipe wins; a flush in IDLE blocks acceptance.
    always_comb begin
        w_accept = (r_state == DivIdle) && !annul_i && (req0_valid || req1_valid);
        w_sel1   = !req0_valid;
        if (w_sel1) begin
            w_sgn = req1_signed;
            w_a   = req1_a;
            w_b   = req1_b;
        end else begin
            w_sgn = req0_signed;
            w_a   = req0_a;
            w_b   = req0_b;
        end
        w_a_mag = mag32(w_a, w_sgn);
        w_b_mag = mag32(w_b, w_sgn);
    end

    // Sign fix-up of the last iteration; a zero divisor returns all-ones and the raw dividend.
    always_comb begin
        if (r_b_zero) begin
            w_final = {r_a, {DataW{1'b1}}};
        end else begin
            w_final[DataW-1:0]       = r_neg_q ? ({DataW{1'b0}} - w_quo_nxt) : w_quo_nxt;
            w_final[ResultW-1:DataW] = r_neg_r ? ({DataW{1'b0}} - w_rem_nxt) : w_rem_nxt;
        end
    end

`ifdef DIV_EARLY_OUT_EN
    // Quotient is trivially zero (or the divide-by-zero pattern) when the divisor dominates.
    always_comb begin
        w_early = (w_b == {DataW{1'b0}}) || (w_a_mag < w_b_mag);
        if (w_b == {DataW{1'b0}}) begin
            w_early_res = {w_a, {DataW{1'b1}}};
        end else begin
            w_early_res = {w_a, {DataW{1'b0}}};
        end
    end
`endif

    div_core u_core (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_step    (r_state == DivBusy),
        .i_a_mag   (w_a_mag),
        .i_b_mag   (w_b_mag),
        .o_quo_nxt (w_quo_nxt),
        .o_rem_nxt (w_rem_nxt)
    );

    // Scheduler FSM; a flush beats a completing iteration and leaves result_o untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= DivIdle;
            r_cnt    <= {CntW{1'b0}};
            r_a      <= {DataW{1'b0}};
            r_b_zero <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= {ResultW{1'b0}};
            r_valid  <= 1'b0;
            r_id     <= 1'b0;
        end else begin
            case (r_state)
                DivIdle: begin
                    r_valid <= 1'b0;
                    if (w_accept) begin
                        r_cnt    <= {CntW{1'b0}};
                        r_a      <= w_a;
                        r_b_zero <= (w_b == {DataW{1'b0}});
                        r_neg_q  <= w_sgn && (w_a[DataW-1] ^ w_b[DataW-1]);
                        r_neg_r  <= w_sgn && w_a[DataW-1];
                        r_id     <= w_sel1;
`ifdef DIV_EARLY_OUT_EN
                        if (w_early) begin
                            r_state  <= DivDone;
                            r_result <= w_early_res;
                            r_valid  <= 1'b1;
                        end else begin
                            r_state  <= DivBusy;
                        end
`else
                        r_state <= DivBusy;
`endif
                    end else begin
                        r_state <= DivIdle;
                    end
                end
                DivBusy: begin
                    if (annul_i) begin
                        r_state <= DivIdle;
                    end else if (r_cnt == LastCnt) begin
                        r_state  <= DivDone;
                        r_result <= w_final;
                        r_valid  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + {{(CntW-1){1'b0}}, 1'b1};
                    end
                end
                DivDone: begin
                    r_state <= DivIdle;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= DivIdle;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign result_o       = r_result;
    assign result_valid_o = r_valid && !annul_i;
    assign result_id_o    = r_id;
    assign busy_o         = (r_state != DivIdle);
    assign stall0_o       = req0_valid && !(result_valid_o && (result_id_o == 1'b0));
    assign stall1_o       = req1_valid && !(result_valid_o && (result_id_o == 1'b1));
endmodule
